// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded ID state each cycle or inserts a
// bubble, and raises the load-use stall that freezes PC and IF/ID.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [8:0]  id_ctrl,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs_idx,
  input  logic [4:0]  id_rt_idx,
  input  logic [4:0]  id_rd_idx,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [8:0]  ex_ctrl,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs_idx,
  output logic [4:0]  ex_rt_idx,
  output logic [4:0]  ex_dest_idx,
  output logic [15:0] bubble_count
);

  // control word bit positions
  localparam int C_REGDST  = 8;
  localparam int C_BRANCH  = 7;
  localparam int C_MEMREAD = 6;
  localparam int C_MEMWR   = 4;
  localparam int C_JUMP    = 1;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  dest_idx;
  } ex_t;

  ex_t         ex_q;
  ex_t         id_pkt;
  logic        flush_pending;
  logic [15:0] bubble_q;
  logic        id_uses_rt;
  logic        hazard;
  logic        kill;

  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = 1'b1;
    id_pkt.ctrl     = id_ctrl;
    id_pkt.pc       = id_pc;
    id_pkt.rs_data  = id_rs_data;
    id_pkt.rt_data  = id_rt_data;
    id_pkt.imm      = id_imm;
    id_pkt.rs_idx   = id_rs_idx;
    id_pkt.rt_idx   = id_rt_idx;
    id_pkt.dest_idx = id_ctrl[C_REGDST] ? id_rd_idx : id_rt_idx;
  end

  // jumps carry no rt source even when the branch bit is also set
  assign id_uses_rt = id_ctrl[C_REGDST] | id_ctrl[C_MEMWR] |
                      (id_ctrl[C_BRANCH] & ~id_ctrl[C_JUMP]);

  assign hazard = id_valid & ex_q.valid & ex_q.ctrl[C_MEMREAD] &
                  (ex_q.dest_idx != 5'd0) &
                  ((ex_q.dest_idx == id_rs_idx) |
                   ((ex_q.dest_idx == id_rt_idx) & id_uses_rt));

  assign id_stall = hazard | ex_stall;
  assign kill     = flush | flush_pending;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q          <= '0;
      flush_pending <= 1'b0;
      bubble_q      <= '0;
    end else if (ex_stall) begin
      // hold; a flush seen while stalled is applied on the first free edge
      if (flush) flush_pending <= 1'b1;
    end else if (kill) begin
      ex_q          <= '0;
      flush_pending <= 1'b0;
      if (bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
    end else if (hazard) begin
      ex_q <= '0;
      if (bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
    end else if (!id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_pkt;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_pc        = ex_q.pc;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs_idx    = ex_q.rs_idx;
  assign ex_rt_idx    = ex_q.rt_idx;
  assign ex_dest_idx  = ex_q.dest_idx;
  assign bubble_count = bubble_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register with load-use hazard detection and flush/stall handling. Sits between the decode stage (control decoder, register file read, sign extender) and the execute stage. Each cycle it captures the decoded control bits and operands of the instruction in ID, or inserts a bubble. It generates the stall that freezes PC and IF/ID on a load-use hazard.

## Interface
- No parameters; data width fixed at 32, register index width 5, control word 9 bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_ctrl` in 9: control word {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, jump, word}, regDst at bit 8, word at bit 0.
- `id_pc` in 32: PC+4 of the ID instruction.
- `id_rs_data`, `id_rt_data` in 32 each: register file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_rs_idx`, `id_rt_idx`, `id_rd_idx` in 5 each: instruction register fields.
- `ex_stall` in 1: EX/MEM cannot accept; hold ID/EX contents.
- `flush` in 1: taken branch/jump resolved in EX; kill the instruction currently in ID.
- `id_stall` out 1: freeze PC and IF/ID this cycle.
- `ex_valid` out 1; `ex_ctrl` out 9; `ex_pc`, `ex_rs_data`, `ex_rt_data`, `ex_imm` out 32 each; `ex_rs_idx`, `ex_rt_idx`, `ex_dest_idx` out 5 each.
- `bubble_count` out 16: saturating count of inserted bubbles.

## Operation
- `ex_dest_idx` is captured as `id_rd_idx` if `id_ctrl[8]` (regDst) is 1, else `id_rt_idx`.
- ID uses rt when regDst, memWrite, or (branch and not jump) is set.
- Load-use hazard (combinational) requires all of the following:
  - `id_valid`, `ex_valid`, and `ex_ctrl` memRead are 1.
  - `ex_dest_idx` is not 0.
  - `ex_dest_idx` equals `id_rs_idx`, or equals `id_rt_idx` and ID uses rt.
- `id_stall` = hazard OR `ex_stall`.
- A bubble sets `ex_valid`=0 and `ex_ctrl`=0 (all control bits 0, same as the decoder default). Data, index and PC outputs are don't-care but are driven to 0.
- `flush_pending` is an internal 1-bit register.
- Next-state priority, highest first:
  1. `reset_n`=0: all outputs 0, `flush_pending`=0, `bubble_count`=0.
  2. `ex_stall`=1: hold all outputs. If `flush`=1, set `flush_pending`.
  3. `flush` OR `flush_pending`: load a bubble, clear `flush_pending`.
  4. Hazard: load a bubble. ID is held by `id_stall` and re-presents next cycle.
  5. `id_valid`=0: load a bubble.
  6. Otherwise: capture all ID inputs, `ex_valid`=1.
- `bubble_count` increments on cases 3 and 4 only, and saturates at 0xFFFF. Case 5 is not counted.
- Index 0 as a destination never causes a hazard.

## Timing
- Latency: one cycle from ID inputs to `ex_*` outputs.
- `id_stall` is combinational from registered EX state and current ID inputs, valid in the same cycle. It has no combinational path from `flush`.
- A load-use hazard costs exactly one bubble. In the next cycle the load has left ID/EX, so the hazard clears unless `ex_stall` holds it.
- `flush` is a one-cycle pulse. If it coincides with `ex_stall`, the kill is deferred until the first non-stalled edge, and exactly one ID instruction is killed.
- Reset mid-operation: on the next edge all outputs and counters read 0, regardless of `ex_stall` or `flush`.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with `id_valid`=1 -> `ex_valid`=0, `ex_ctrl`=0, `bubble_count`=0, `id_stall`=0.
- **ADD pass-through:** `id_ctrl`=9'b100000100, rs=1, rt=2, rd=3, data 0x5/0x7 -> next cycle `ex_valid`=1, `ex_dest_idx`=3, `ex_rs_data`=0x5.
- **Load-use:** LDW (9'b001101101, rt=4) then ADD with rs=4 -> `id_stall`=1 for one cycle, one bubble, `bubble_count`=1, ADD captured on the following edge. Repeat with the load's rt=0 -> no stall.
- **Store/JUMP rt use:** load to r5, then STB with rt=5 -> stall. Load to r5, then JUMP with rt=5 -> no stall.
- **Flush:** pulse `flush` with a valid ID instruction -> bubble next cycle, `bubble_count`+1, next ID instruction captured normally.
- **Flush during ex_stall:** `ex_stall`=1 for 3 cycles with a `flush` pulse in cycle 1 -> outputs held all 3 cycles, one bubble on the first unstalled edge, then normal capture.
